mux_arbiter: RTL and testbench
==============================

Name: mux_arbiter

Overview:
- Two-requester, round-robin, burst-aware arbiter that shares one 32-bit datapath channel.
- Drives the select of the existing 2:1 Mux and registers the chosen word toward the consumer with a valid/ready handshake.
- Sits between two producers, for example an operand source and a writeback source, and a single downstream consumer.
- A grant is held for a whole burst, up to MAX_BURST beats.

Parameters:
- DATA_W, 32, width of the data words; must match the Mux operand width.
- MAX_BURST, 8, maximum number of beats per grant before the grant is forcibly released; legal range 1..255.
- CNT_W, 8, width of the beat counter; must satisfy 2^CNT_W > MAX_BURST.

Ports:
- clk  in  1  single system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a word.
- req0_data  in  DATA_W  requester 0 word; feeds Mux OP1.
- req0_last  in  1  qualifies the req0 word as the final beat of its burst.
- req0_ready  out  1  the req0 word is accepted this cycle.
- req1_valid  in  1  requester 1 has a word.
- req1_data  in  DATA_W  requester 1 word; feeds Mux OP2.
- req1_last  in  1  qualifies the req1 word as the final beat of its burst.
- req1_ready  out  1  the req1 word is accepted this cycle.
- out_valid  out  1  the output register holds a word.
- out_data  out  DATA_W  registered word.
- out_src  out  1  source of out_data (0 = req0, 1 = req1).
- out_ready  in  1  consumer accepts the word.
- selM  out  1  current grant / Mux select, exported for debug.
- burst_abort  out  1  one-cycle pulse when a grant is released because MAX_BURST was reached without a last beat.

Behaviour:
- Reset (rst=1 at the edge):
  - state=IDLE, prio=0, beat_cnt=0.
  - selM=0, out_valid=0, out_data=0, out_src=0, burst_abort=0.
  - req0_ready=req1_ready=0.
  - Reset mid-burst discards the held word and the grant; nothing is flushed.
- States: IDLE, OWN0, OWN1. selM=0 in IDLE and OWN0; selM=1 in OWN1.
- IDLE:
  - Both ready outputs are 0.
  - If exactly one reqN_valid=1, go to OWNN next cycle.
  - If both are valid, go to OWN(prio).
  - No word is accepted in the arbitration cycle, so first-beat latency is valid to ready = 1 cycle minimum.
- OWNx:
  - reqx_ready = !out_valid || out_ready, computed combinationally; the other requester's ready=0.
  - A beat transfers when reqx_valid && reqx_ready. On transfer, at the next edge: out_data <= Mux res, out_src <= x, out_valid <= 1, beat_cnt <= beat_cnt+1.
  - Accept-to-out_valid latency is 1 cycle.
- Release:
  - On a transfer with reqx_last=1: state <= IDLE, prio <= ~x, beat_cnt <= 0.
  - On a transfer without last where beat_cnt+1 == MAX_BURST: the same release, plus burst_abort=1 for that one cycle. The requester's remaining beats re-arbitrate later.
- Valid bubbles:
  - If reqx_valid drops mid-burst, the state is held in OWNx indefinitely.
  - No timeout other than the beat cap.
- Output register:
  - If out_valid && out_ready and no new transfer, out_valid <= 0; out_data keeps its last value.
  - Simultaneous out_ready and a new transfer reloads the register and out_valid stays 1, giving full throughput of 1 beat/cycle within a burst.
  - When out_valid=1 and out_ready=0, ready=0 and the register is stable: no drop, no overwrite.
- Fairness:
  - prio only changes on release.
  - With both requesters continuously valid, bursts alternate 0,1,0,1, each separated by one IDLE cycle.
- MAX_BURST=1: every beat is released immediately; burst_abort pulses whenever last=0.

Decomposition:
- Shared package: state encodings ST_IDLE=2'd0, ST_OWN0=2'd1, ST_OWN1=2'd2; the source IDs SRC0/SRC1.
- One natural sub-module: the existing Mux, instantiated with OP1=req0_data, OP2=req1_data and selM driven by the FSM.
- The FSM, beat counter, priority bit and output register stay in mux_arbiter.

Test Plan:
- Reset: assert rst for 2 cycles during an active burst, then release.
  - Every output is 0 and state is IDLE.
  - The next grant goes to req0 when both requesters are valid.
- Single burst, req0 only:
  - Stimulus: words 0x11111111, 0x22222222, 0x33333333, last on the third word, out_ready=1.
  - Response: ready high for 3 cycles starting 1 cycle after valid; out_data appears one cycle after each acceptance; out_src=0; back to IDLE; prio=1.
- Contention: both requesters valid continuously, each sending 2-beat bursts.
  - Grant order is req0, req1, req0, with exactly one IDLE cycle between bursts.
  - The loser's ready stays 0 throughout the other's burst.
- Backpressure: hold out_ready=0 for 4 cycles while req1 streams 0xA5A5A5A5, 0x5A5A5A5A.
  - out_data holds 0xA5A5A5A5 and req1_ready=0 while out_ready=0.
  - After release the words arrive in order, none lost or duplicated.
- Beat cap: MAX_BURST=4, req1 sends 6 beats with no last.
  - The grant is released after beat 4.
  - burst_abort is a single-cycle pulse.
  - Beats 5-6 are transferred only after re-arbitration.
- Throughput: req0 sends a 3-beat burst with out_ready=1 every cycle.
  - out_valid stays 1 for 3 consecutive cycles with a new word each cycle, exercising the simultaneous drain-and-load case.

Source files
------------

// File: rtl/mux_arbiter_pkg.sv
// Shared definitions for the two-requester burst arbiter: FSM encodings,
// source identifiers and a small helper used when handing priority over.
package mux_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_e;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    // Priority after a release always points at the requester that did not own the grant.
    function automatic logic other_src(input logic src);
        return ~src;
    endfunction

endpackage

// File: rtl/mux_arbiter_mux.sv
// The 2:1 datapath Mux: op1 is selected when sel is SRC0, op2 when sel is SRC1.
module mux_arbiter_mux
    import mux_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  logic              sel,
    output logic [DATA_W-1:0] res
);

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
            assign res[gi] = (sel == SRC1) ? op2[gi] : op1[gi];
        end
    endgenerate

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin, burst-aware arbiter sharing one datapath channel between two
// producers; the granted word is registered toward a valid/ready consumer.
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_last,
    output logic              req1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    input  logic              out_ready,
    output logic              selM,
    output logic              burst_abort
);

    state_e            state_q, state_d;
    logic              prio_q, prio_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_src_q, out_src_d;
    logic              burst_abort_q, burst_abort_d;

    logic              sel_m;
    logic              grant_valid;
    logic              grant_last;
    logic              grant_ready;
    logic              transfer;
    logic              cap_hit;
    logic              release_grant;
    logic [CNT_W:0]    beat_inc;
    logic [DATA_W-1:0] mux_res;

    mux_arbiter_mux #(
        .DATA_W (DATA_W)
    ) u_mux (
        .op1 (req0_data),
        .op2 (req1_data),
        .sel (sel_m),
        .res (mux_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ready is only offered by the owner, and only when the output register can take a word.
    always_comb begin
        sel_m      = SRC0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            ST_OWN0: req0_ready = !out_valid_q || out_ready;
            ST_OWN1: begin
                sel_m      = SRC1;
                req1_ready = !out_valid_q || out_ready;
            end
            default: ;
        endcase
    end

    assign grant_valid   = (sel_m == SRC1) ? req1_valid : req0_valid;
    assign grant_last    = (sel_m == SRC1) ? req1_last  : req0_last;
    assign grant_ready   = req0_ready | req1_ready;
    assign transfer      = grant_valid & grant_ready;
    assign beat_inc      = {1'b0, beat_cnt_q} + (CNT_W + 1)'(1);
    assign cap_hit       = (beat_inc == (CNT_W + 1)'(MAX_BURST));
    assign release_grant = transfer & (grant_last | cap_hit);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req0_valid && req1_valid) begin
                    state_d = (prio_q == SRC1) ? ST_OWN1 : ST_OWN0;
                end else if (req0_valid) begin
                    state_d = ST_OWN0;
                end else if (req1_valid) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (release_grant) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        prio_d        = prio_q;
        beat_cnt_d    = beat_cnt_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_src_d     = out_src_q;
        burst_abort_d = 1'b0;

        if (transfer) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_res;
            out_src_d   = sel_m;
            beat_cnt_d  = beat_inc[CNT_W-1:0];
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // A cap release without last leaves the rest of the burst to a later grant.
        if (release_grant) begin
            prio_d        = other_src(sel_m);
            beat_cnt_d    = '0;
            burst_abort_d = !grant_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q        <= SRC0;
            beat_cnt_q    <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_src_q     <= SRC0;
            burst_abort_q <= 1'b0;
        end else begin
            prio_q        <= prio_d;
            beat_cnt_q    <= beat_cnt_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_src_q     <= out_src_d;
            burst_abort_q <= burst_abort_d;
        end
    end

    assign selM        = sel_m;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_src     = out_src_q;
    assign burst_abort = burst_abort_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a behavioural model.
module tb_mux_arbiter;

    localparam int DW = 32;
    localparam int MB = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_last, req0_ready;
    logic [DW-1:0] req0_data;
    logic          req1_valid, req1_last, req1_ready;
    logic [DW-1:0] req1_data;
    logic          out_valid, out_src, out_ready, selM, burst_abort;
    logic [DW-1:0] out_data;

    always #5 clk = ~clk;

    mux_arbiter #(
        .DATA_W    (DW),
        .MAX_BURST (MB),
        .CNT_W     (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_data   (req0_data),
        .req0_last   (req0_last),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_data   (req1_data),
        .req1_last   (req1_last),
        .req1_ready  (req1_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_src     (out_src),
        .out_ready   (out_ready),
        .selM        (selM),
        .burst_abort (burst_abort)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 0;
    bit sb_en   = 0;

    // Behavioural model: owner is -1 when nobody holds the channel.
    int          m_owner = -1;
    int          m_prio  = 0;
    int          m_beats = 0;
    bit          m_ov    = 0;
    logic [31:0] m_od    = '0;
    bit          m_os    = 0;
    bit          m_ab    = 0;

    // Producer queues ({last, data}), per-source expected streams and event logs.
    logic [32:0] q0[$], q1[$];
    logic [31:0] exp0[$], exp1[$];
    bit          en0 = 1, en1 = 1;
    bit          acc0 = 0, acc1 = 0;
    int          a_src[$], a_cyc[$], c_src[$], c_cyc[$], ab_cyc[$];
    logic [31:0] a_dat[$], c_dat[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit v, l, xfer, ab;
        logic [31:0] d;
        int own;
        cyc++;
        if (rst) begin
            m_owner = -1; m_prio = 0; m_beats = 0;
            m_ov = 0; m_od = '0; m_os = 0; m_ab = 0;
        end else begin
            ab = 0;
            if (m_owner < 0) begin
                if (req0_valid && req1_valid) m_owner = m_prio;
                else if (req0_valid)          m_owner = 0;
                else if (req1_valid)          m_owner = 1;
                if (m_ov && out_ready) m_ov = 0;
            end else begin
                own  = m_owner;
                v    = (own == 1) ? req1_valid : req0_valid;
                l    = (own == 1) ? req1_last  : req0_last;
                d    = (own == 1) ? req1_data  : req0_data;
                xfer = v && (!m_ov || out_ready);
                if (xfer) begin
                    m_od = d; m_os = (own == 1); m_ov = 1; m_beats++;
                    if (l || m_beats == MB) begin
                        m_owner = -1; m_prio = 1 - own; m_beats = 0; ab = !l;
                    end
                end else if (m_ov && out_ready) begin
                    m_ov = 0;
                end
            end
            m_ab = ab;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic compare_step();
        bit r0, r1;
        logic [31:0] e;
        acc0 = req0_valid && req0_ready && !rst;
        acc1 = req1_valid && req1_ready && !rst;
        if (chk_en) begin
            r0 = (m_owner == 0) && (!m_ov || out_ready);
            r1 = (m_owner == 1) && (!m_ov || out_ready);
            check("out_valid",   32'(out_valid),   32'(m_ov));
            check("out_data",    out_data,         m_od);
            check("out_src",     32'(out_src),     32'(m_os));
            check("selM",        32'(selM),        32'(m_owner == 1));
            check("burst_abort", 32'(burst_abort), 32'(m_ab));
            check("req0_ready",  32'(req0_ready),  32'(r0));
            check("req1_ready",  32'(req1_ready),  32'(r1));
        end
        if (acc0) begin a_src.push_back(0); a_dat.push_back(req0_data); a_cyc.push_back(cyc); end
        if (acc1) begin a_src.push_back(1); a_dat.push_back(req1_data); a_cyc.push_back(cyc); end
        if (burst_abort && !rst) ab_cyc.push_back(cyc);
        if (out_valid && out_ready && !rst) begin
            c_src.push_back(int'(out_src)); c_dat.push_back(out_data); c_cyc.push_back(cyc);
            if (sb_en) begin
                if (out_src == 1'b0) begin
                    if (exp0.size() == 0) check("sb_extra0", out_data, 32'hDEAD0000);
                    else begin e = exp0.pop_front(); check("sb_order0", out_data, e); end
                end else begin
                    if (exp1.size() == 0) check("sb_extra1", out_data, 32'hDEAD0001);
                    else begin e = exp1.pop_front(); check("sb_order1", out_data, e); end
                end
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        compare_step();
    end

    task automatic apply();
        req0_valid = en0 && (q0.size() > 0);
        req0_data  = (q0.size() > 0) ? q0[0][31:0] : '0;
        req0_last  = (q0.size() > 0) ? q0[0][32]   : 1'b0;
        req1_valid = en1 && (q1.size() > 0);
        req1_data  = (q1.size() > 0) ? q1[0][31:0] : '0;
        req1_last  = (q1.size() > 0) ? q1[0][32]   : 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (acc0 && q0.size() > 0) void'(q0.pop_front());
        if (acc1 && q1.size() > 0) void'(q1.pop_front());
        apply();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push0(input logic [31:0] d, input bit l);
        q0.push_back({l, d});
        if (sb_en) exp0.push_back(d);
        apply();
    endtask

    task automatic push1(input logic [31:0] d, input bit l);
        q1.push_back({l, d});
        if (sb_en) exp1.push_back(d);
        apply();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, la, lc, lb, done;
        int c_srcs[8];
        int c_offs[8];
        logic [31:0] wd[3];

        rst = 1; out_ready = 1;
        apply();
        step();
        chk_en = 1;
        step();
        rst = 0;

        // Reset in the middle of an active burst.
        for (int i = 0; i < 5; i++) push0(32'hC0DE0000 + 32'(i), 1'b0);
        idle(3);
        rst = 1;
        step();
        q0.delete();
        apply();
        step();
        rst = 0;
        @(negedge clk);
        check("rst.out_valid",   32'(out_valid),   32'd0);
        check("rst.out_data",    out_data,         32'd0);
        check("rst.out_src",     32'(out_src),     32'd0);
        check("rst.selM",        32'(selM),        32'd0);
        check("rst.burst_abort", 32'(burst_abort), 32'd0);
        check("rst.req0_ready",  32'(req0_ready),  32'd0);
        check("rst.req1_ready",  32'(req1_ready),  32'd0);
        step();
        sb_en = 1;
        la = a_src.size();
        push0(32'h0000AAAA, 1'b1);
        push1(32'h0000BBBB, 1'b1);
        idle(6);
        check("rst.nbeats", 32'(a_src.size() - la), 32'd2);
        if (a_src.size() >= la + 2) begin
            check("rst.first_grant", 32'(a_src[la]),     32'd0);
            check("rst.second_grant", 32'(a_src[la + 1]), 32'd1);
        end

        // Single req0 burst with full throughput downstream.
        t0 = cyc; la = a_src.size(); lc = c_src.size();
        push0(32'h11111111, 1'b0);
        push0(32'h22222222, 1'b0);
        push0(32'h33333333, 1'b1);
        idle(6);
        check("single.nbeats", 32'(a_src.size() - la), 32'd3);
        check("single.nout",   32'(c_src.size() - lc), 32'd3);
        if (a_src.size() >= la + 3 && c_src.size() >= lc + 3) begin
            for (int i = 0; i < 3; i++) begin
                check("single.acc_cyc", 32'(a_cyc[la + i] - t0), 32'(i + 1));
                check("single.out_cyc", 32'(c_cyc[lc + i] - a_cyc[la + i]), 32'd1);
                check("single.out_src", 32'(c_src[lc + i]), 32'd0);
            end
            check("single.w0", c_dat[lc],     32'h11111111);
            check("single.w1", c_dat[lc + 1], 32'h22222222);
            check("single.w2", c_dat[lc + 2], 32'h33333333);
        end

        // Back-to-back drain-and-load: out_valid held with a fresh word every cycle.
        wd[0] = 32'h0BADF00D; wd[1] = 32'h12345678; wd[2] = 32'hFEEDBEEF;
        push0(wd[0], 1'b0); push0(wd[1], 1'b0); push0(wd[2], 1'b1);
        idle(2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("thru.out_valid", 32'(out_valid), 32'd1);
            check("thru.out_data",  out_data,       wd[i]);
            step();
        end
        @(negedge clk);
        check("thru.drained", 32'(out_valid), 32'd0);
        idle(3);

        // Backpressure on a req1 stream.
        t0 = cyc; lc = c_src.size();
        push1(32'hA5A5A5A5, 1'b0);
        push1(32'h5A5A5A5A, 1'b1);
        idle(2);
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp.out_data",   out_data,          32'hA5A5A5A5);
            check("bp.req1_ready", 32'(req1_ready),   32'd0);
            check("bp.out_valid",  32'(out_valid),    32'd1);
            step();
        end
        out_ready = 1;
        idle(4);
        check("bp.nout", 32'(c_src.size() - lc), 32'd2);
        if (c_src.size() >= lc + 2) begin
            check("bp.w0",     c_dat[lc],     32'hA5A5A5A5);
            check("bp.w1",     c_dat[lc + 1], 32'h5A5A5A5A);
            check("bp.w0_cyc", 32'(c_cyc[lc] - t0), 32'd6);
        end

        // Contention: both requesters with 2-beat bursts.
        t0 = cyc; la = a_src.size();
        c_srcs = '{0, 0, 1, 1, 0, 0, 1, 1};
        c_offs = '{1, 2, 4, 5, 7, 8, 10, 11};
        for (int i = 0; i < 4; i++) begin
            push0(32'h00C00000 + 32'(i), i[0]);
            push1(32'h00C10000 + 32'(i), i[0]);
        end
        idle(14);
        check("cont.nbeats", 32'(a_src.size() - la), 32'd8);
        if (a_src.size() >= la + 8) begin
            for (int i = 0; i < 8; i++) begin
                check("cont.src", 32'(a_src[la + i]), 32'(c_srcs[i]));
                check("cont.cyc", 32'(a_cyc[la + i] - t0), 32'(c_offs[i]));
            end
        end

        // Beat cap: six beats without last, closed by a seventh with last.
        t0 = cyc; la = a_src.size(); lb = ab_cyc.size();
        for (int i = 0; i < 7; i++) push1(32'h00CA0000 + 32'(i), i == 6);
        idle(10);
        check("cap.nbeats", 32'(a_src.size() - la), 32'd7);
        check("cap.npulse", 32'(ab_cyc.size() - lb), 32'd1);
        if (ab_cyc.size() >= lb + 1) check("cap.pulse_cyc", 32'(ab_cyc[lb] - t0), 32'd5);
        if (a_src.size() >= la + 7) begin
            check("cap.beat4_cyc", 32'(a_cyc[la + 3] - t0), 32'd4);
            check("cap.beat5_cyc", 32'(a_cyc[la + 4] - t0), 32'd6);
            check("cap.beat5_dat", a_dat[la + 4], 32'h00CA0004);
        end

        // Randomized traffic with bubbles and backpressure.
        for (int n = 0; n < 3000; n++) begin
            step();
            out_ready = ($urandom_range(0, 3) != 0);
            en0 = ($urandom_range(0, 4) != 0);
            en1 = ($urandom_range(0, 4) != 0);
            if (q0.size() < 3 && $urandom_range(0, 1) == 1) push0($urandom, $urandom_range(0, 3) == 0);
            if (q1.size() < 3 && $urandom_range(0, 1) == 1) push1($urandom, $urandom_range(0, 3) == 0);
            apply();
        end
        en0 = 1; en1 = 1; out_ready = 1;
        push0(32'h0E0E0E0E, 1'b1);
        push1(32'h1E1E1E1E, 1'b1);
        done = 0;
        for (int n = 0; n < 300 && done == 0; n++) begin
            step();
            if (q0.size() == 0 && q1.size() == 0 && !out_valid) done = 1;
        end
        check("drain.done", 32'(done), 32'd1);
        check("drain.exp0_empty", 32'(exp0.size()), 32'd0);
        check("drain.exp1_empty", 32'(exp1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
